// File: rtl/bus_responder.sv
// Bus-transfer responder: moves a byte from a decoded source onto a decoded
// destination each cycle, stalling the control unit for external RAM accesses.
module bus_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  inflags,
  input  logic [2:0]  outflags,
  input  logic [7:0]  in_port,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  bus,
  output logic        stall,
  output logic [7:0]  out_port,
  output logic        out_valid,
  output logic [7:0]  reg_a
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [3:0] DST_A   = 4'd1;
  localparam logic [3:0] DST_B   = 4'd2;
  localparam logic [3:0] DST_C   = 4'd3;
  localparam logic [3:0] DST_D   = 4'd4;
  localparam logic [3:0] DST_MRL = 4'd5;
  localparam logic [3:0] DST_MRH = 4'd6;
  localparam logic [3:0] DST_RAM = 4'd7;
  localparam logic [3:0] DST_OUT = 4'd8;
  localparam logic [2:0] SRC_RAM = 3'd5;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [7:0]  marl_q, marl_d, marh_q, marh_d;
  logic [7:0]  out_port_q, out_port_d, wdata_q, wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  dst_q, dst_d;
  logic [15:0] addr_q, addr_d;

  logic [7:0]  src_val, bus_val, load_val;
  logic [3:0]  load_dst;
  logic        load_en, req, we, src_ram, dst_ram;

  always_comb begin
    src_val = 8'h00;
    case (outflags)
      3'd1:    src_val = a_q;
      3'd2:    src_val = b_q;
      3'd3:    src_val = c_q;
      3'd4:    src_val = d_q;
      3'd6:    src_val = in_port;
      default: src_val = 8'h00;
    endcase
  end

  // RAM-to-RAM is a no-op; a pending read drives the bus from mem_rdata.
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bus_val  = 8'h00;
    req      = 1'b0;
    we       = 1'b0;
    load_en  = 1'b0;
    load_dst = 4'd0;
    load_val = 8'h00;
    src_ram  = (outflags == SRC_RAM);
    dst_ram  = (inflags == DST_RAM);
    case (state_q)
      IDLE: begin
        bus_val = src_val;
        if (src_ram && !dst_ram) begin
          req     = 1'b1;
          state_d = RD_WAIT;
          dst_d   = inflags;
          addr_d  = {marh_q, marl_q};
        end else if (dst_ram && !src_ram) begin
          req     = 1'b1;
          we      = 1'b1;
          state_d = WR_WAIT;
          wdata_d = src_val;
          addr_d  = {marh_q, marl_q};
        end else if (!src_ram) begin
          load_en  = 1'b1;
          load_dst = inflags;
          load_val = src_val;
        end
      end
      RD_WAIT: begin
        bus_val = mem_rdata;
        req     = 1'b1;
        if (mem_ack) begin
          load_en  = 1'b1;
          load_dst = dst_q;
          load_val = mem_rdata;
          state_d  = IDLE;
        end
      end
      WR_WAIT: begin
        req = 1'b1;
        we  = 1'b1;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    marl_d      = marl_q;
    marh_d      = marh_q;
    out_port_d  = out_port_q;
    out_valid_d = 1'b0;
    if (load_en) begin
      case (load_dst)
        DST_A:   a_d    = load_val;
        DST_B:   b_d    = load_val;
        DST_C:   c_d    = load_val;
        DST_D:   d_d    = load_val;
        DST_MRL: marl_d = load_val;
        DST_MRH: marh_d = load_val;
        DST_OUT: begin
          out_port_d  = load_val;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      c_q         <= 8'h00;
      d_q         <= 8'h00;
      marl_q      <= 8'h00;
      marh_q      <= 8'h00;
      out_port_q  <= 8'h00;
      out_valid_q <= 1'b0;
      wdata_q     <= 8'h00;
      dst_q       <= 4'd0;
      addr_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      marl_q      <= marl_d;
      marh_q      <= marh_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      dst_q       <= dst_d;
      addr_q      <= addr_d;
    end
  end

  // Request strobes are gated so they read 0 while reset is held.
  assign mem_req   = req & rst_n;
  assign mem_we    = we & rst_n;
  assign stall     = req & rst_n;
  assign mem_addr  = (state_q == IDLE) ? {marh_q, marl_q} : addr_q;
  assign mem_wdata = wdata_q;
  assign bus       = bus_val;
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;
  assign reg_a     = a_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios followed by random
// transfers checked against a transfer-level model with a sparse RAM.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  inflags;
  logic [2:0]  outflags;
  logic [7:0]  in_port;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [7:0]  bus, out_port, reg_a;
  logic        stall, out_valid;

  bus_responder dut (
    .clk(clk), .rst_n(rst_n), .inflags(inflags), .outflags(outflags),
    .in_port(in_port), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus(bus),
    .stall(stall), .out_port(out_port), .out_valid(out_valid), .reg_a(reg_a)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: registers A..D, MAR bytes, output register and RAM contents.
  logic [7:0] mRegs [1:4];
  logic [7:0] mMarl, mMarh, mOut;
  logic       mOutValid;
  logic [7:0] mem [logic [15:0]];
  logic [2:0] waitSrc;
  logic [3:0] waitDst;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] srcValue(input logic [2:0] src, input logic [7:0] inVal);
    if (src >= 3'd1 && src <= 3'd4) return mRegs[int'(src)];
    if (src == 3'd6) return inVal;
    return 8'h00;
  endfunction

  task automatic modelWrite(input logic [3:0] dst, input logic [7:0] val);
    if (dst >= 4'd1 && dst <= 4'd4) mRegs[int'(dst)] = val;
    else if (dst == 4'd5) mMarl = val;
    else if (dst == 4'd6) mMarh = val;
    else if (dst == 4'd8) begin
      mOut      = val;
      mOutValid = 1'b1;
    end
  endtask

  task automatic modelReset();
    for (int i = 1; i <= 4; i++) mRegs[i] = 8'h00;
    mMarl = 8'h00;
    mMarh = 8'h00;
    mOut  = 8'h00;
    mOutValid = 1'b0;
  endtask

  // Called just after a rising edge; returns at the following falling edge.
  task automatic applyStimulus(input logic [2:0] src, input logic [3:0] dst,
                               input logic [7:0] inVal);
    outflags = src;
    inflags  = dst;
    in_port  = inVal;
    @(negedge clk);
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete bus transfer, including any RAM handshake, with checks.
  task automatic doTransfer(input logic [2:0] src, input logic [3:0] dst,
                            input logic [7:0] inVal, input int nWait);
    logic [7:0]  sv;
    logic [7:0]  rd;
    logic [15:0] addr;
    mOutValid = 1'b0;
    sv   = srcValue(src, inVal);
    addr = {mMarh, mMarl};
    if (src == 3'd5 && dst == 4'd7) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      applyStimulus(src, dst, inVal);
      checkOutput("noop_req", 16'(mem_req), 16'd0);
      checkOutput("noop_stall", 16'(stall), 16'd0);
      checkOutput("noop_bus", 16'(bus), 16'h00);
      finishCycle();
      mem_ack = 1'b0;
    end else if (src == 3'd5) begin
      mem_ack = 1'b0;
      applyStimulus(src, dst, inVal);
      checkOutput("rd_req", 16'(mem_req), 16'd1);
      checkOutput("rd_we", 16'(mem_we), 16'd0);
      checkOutput("rd_stall", 16'(stall), 16'd1);
      checkOutput("rd_addr", mem_addr, addr);
      finishCycle();
      for (int k = 0; k < nWait; k++) begin
        mem_rdata = 8'($urandom);
        applyStimulus(waitSrc, waitDst, 8'($urandom));
        checkOutput("rd_wait_stall", 16'(stall), 16'd1);
        checkOutput("rd_wait_we", 16'(mem_we), 16'd0);
        checkOutput("rd_wait_addr", mem_addr, addr);
        checkOutput("rd_wait_a", 16'(reg_a), 16'(mRegs[1]));
        finishCycle();
      end
      rd = mem.exists(addr) ? mem[addr] : 8'($urandom);
      mem[addr] = rd;
      mem_rdata = rd;
      mem_ack   = 1'b1;
      @(negedge clk);
      checkOutput("rd_ack_bus", 16'(bus), 16'(rd));
      checkOutput("rd_ack_stall", 16'(stall), 16'd1);
      finishCycle();
      mem_ack = 1'b0;
      modelWrite(dst, rd);
    end else if (dst == 4'd7) begin
      mem_ack = 1'b0;
      applyStimulus(src, dst, inVal);
      checkOutput("wr_req", 16'(mem_req), 16'd1);
      checkOutput("wr_we", 16'(mem_we), 16'd1);
      checkOutput("wr_stall", 16'(stall), 16'd1);
      checkOutput("wr_bus", 16'(bus), 16'(sv));
      checkOutput("wr_addr", mem_addr, addr);
      finishCycle();
      for (int k = 0; k <= nWait; k++) begin
        mem_ack = (k == nWait);
        applyStimulus(waitSrc, waitDst, 8'($urandom));
        checkOutput("wr_wait_data", 16'(mem_wdata), 16'(sv));
        checkOutput("wr_wait_we", 16'(mem_we), 16'd1);
        checkOutput("wr_wait_bus", 16'(bus), 16'h00);
        checkOutput("wr_wait_addr", mem_addr, addr);
        checkOutput("wr_wait_a", 16'(reg_a), 16'(mRegs[1]));
        finishCycle();
      end
      mem_ack = 1'b0;
      mem[addr] = sv;
    end else begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      applyStimulus(src, dst, inVal);
      checkOutput("xfer_stall", 16'(stall), 16'd0);
      checkOutput("xfer_req", 16'(mem_req), 16'd0);
      checkOutput("xfer_bus", 16'(bus), 16'(sv));
      finishCycle();
      mem_ack = 1'b0;
      modelWrite(dst, sv);
    end
    outflags = 3'd0;
    inflags  = 4'd0;
    #1;
    checkOutput("end_a", 16'(reg_a), 16'(mRegs[1]));
    checkOutput("end_out_port", 16'(out_port), 16'(mOut));
    checkOutput("end_out_valid", 16'(out_valid), 16'(mOutValid));
    checkOutput("end_stall", 16'(stall), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    inflags   = 4'd0;
    outflags  = 3'd0;
    in_port   = 8'h00;
    mem_rdata = 8'h00;
    mem_ack   = 1'b0;
    waitSrc   = 3'd0;
    waitDst   = 4'd0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_a", 16'(reg_a), 16'h00);
    checkOutput("rst_out_port", 16'(out_port), 16'h00);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_wdata", 16'(mem_wdata), 16'h00);
    checkOutput("rst_addr", mem_addr, 16'h0000);
    checkOutput("rst_req", 16'(mem_req), 16'd0);
    checkOutput("rst_stall", 16'(stall), 16'd0);
    #1 rst_n = 1'b1;

    $display("[TB] register transfer");
    doTransfer(3'd6, 4'd1, 8'h5A, 0);
    checkOutput("dir_a_5a", 16'(reg_a), 16'h5A);
    doTransfer(3'd1, 4'd3, 8'h00, 0);
    doTransfer(3'd3, 4'd8, 8'h00, 0);
    checkOutput("dir_c_5a", 16'(out_port), 16'h5A);

    $display("[TB] RAM read");
    doTransfer(3'd6, 4'd6, 8'h12, 0);
    doTransfer(3'd6, 4'd5, 8'h34, 0);
    mem[16'h1234] = 8'hC3;
    waitSrc = 3'd6;
    waitDst = 4'd5;
    doTransfer(3'd5, 4'd2, 8'h00, 2);
    doTransfer(3'd2, 4'd8, 8'h00, 0);
    checkOutput("dir_b_c3", 16'(out_port), 16'hC3);

    $display("[TB] RAM write");
    doTransfer(3'd6, 4'd1, 8'h77, 0);
    waitSrc = 3'd6;
    waitDst = 4'd1;
    doTransfer(3'd1, 4'd7, 8'hAB, 3);
    checkOutput("dir_wdata_77", 16'(mem_wdata), 16'h77);
    checkOutput("dir_a_77", 16'(reg_a), 16'h77);

    $display("[TB] OUT strobe");
    doTransfer(3'd6, 4'd4, 8'h99, 0);
    doTransfer(3'd4, 4'd8, 8'h00, 0);
    checkOutput("dir_out_99", 16'(out_port), 16'h99);
    finishCycle();
    checkOutput("dir_out_valid_drop", 16'(out_valid), 16'd0);

    $display("[TB] corner cases");
    doTransfer(3'd5, 4'd7, 8'h00, 0);
    doTransfer(3'd6, 4'd12, 8'hFF, 0);
    doTransfer(3'd1, 4'd1, 8'h00, 0);
    doTransfer(3'd1, 4'd8, 8'h00, 0);
    checkOutput("dir_a_kept", 16'(out_port), 16'h77);

    $display("[TB] reset mid-read");
    doTransfer(3'd6, 4'd2, 8'h3C, 0);
    mem_ack = 1'b0;
    applyStimulus(3'd5, 4'd2, 8'h00);
    finishCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", 16'(mem_req), 16'd0);
    checkOutput("mid_rst_stall", 16'(stall), 16'd0);
    outflags = 3'd0;
    inflags  = 4'd0;
    modelReset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    mem_rdata = 8'hEE;
    mem_ack   = 1'b1;
    @(negedge clk);
    checkOutput("late_ack_req", 16'(mem_req), 16'd0);
    checkOutput("late_ack_stall", 16'(stall), 16'd0);
    finishCycle();
    mem_ack = 1'b0;
    doTransfer(3'd2, 4'd8, 8'h00, 0);
    checkOutput("late_ack_b", 16'(out_port), 16'h00);

    $display("[TB] random transfers");
    for (int n = 0; n < 300; n++) begin
      waitSrc = 3'($urandom_range(0, 7));
      waitDst = 4'($urandom_range(0, 15));
      doTransfer(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 8'($urandom), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
